// File: rtl/bus_timer_peripheral_if.sv
// Peripheral bus bundle between the processor and the timer.
// Carries address/data/write strobe, read-data return and the IRQ pair.
interface bus_timer_peripheral_if;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA_IN;
  logic       BUS_WE;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OUT_EN;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_DATA_IN,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_DATA_OUT,
    input  BUS_DATA_OUT_EN,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_DATA_IN,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_DATA_OUT,
    output BUS_DATA_OUT_EN,
    output BUS_INTERRUPT_RAISE
  );
endinterface

// File: rtl/bus_timer_peripheral.sv
// Memory-mapped tick timer with interval IRQ and a tear-free
// 16-bit count snapshot (low byte read latches the high byte).
module bus_timer_peripheral #(
  parameter logic [7:0]  BASE_ADDR        = 8'hF0,
  parameter int          CLK_FREQ_HZ      = 100000000,
  parameter int          TICK_HZ          = 1000,
  parameter logic [15:0] DEFAULT_INTERVAL = 16'd100
) (
  input  logic CLK,
  input  logic RESET,
  bus_timer_peripheral_if.slave bus
);
  localparam int PreTerm = CLK_FREQ_HZ / TICK_HZ - 1;
  localparam int PW = (PreTerm > 0) ? $clog2(PreTerm + 1) : 1;
  localparam logic [PW-1:0] PreMax = PW'(PreTerm);

  logic          en_q, en_d;
  logic          irqen_q, irqen_d;
  logic          pend_q, pend_d;
  logic [15:0]   int_q, int_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    shd_q, shd_d;
  logic [7:0]    dout_q, dout_d;
  logic          oen_q, oen_d;

  logic [7:0] off;
  logic [4:0] sel;
  logic       wr, rd;
  logic       restart, tick, match;
  logic [7:0] rdata;

  always_comb begin
    off = bus.BUS_ADDR - BASE_ADDR;
    sel = {off == 8'd4, off == 8'd3, off == 8'd2,
           off == 8'd1, off == 8'd0};
    wr  = (|sel) & bus.BUS_WE;
    rd  = (|sel) & ~bus.BUS_WE;
    restart = wr & (sel[1] | sel[2] |
                    (sel[0] & bus.BUS_DATA_IN[2]));
    tick  = en_q & (pre_q == PreMax);
    // interval 0 gives 16'hFFFF here, i.e. a 65536-tick period
    match = tick & ~restart & (cnt_q == int_q - 16'd1);
  end

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      sel[0]: rdata = {pend_q, 5'b0, irqen_q, en_q};
      sel[1]: rdata = int_q[7:0];
      sel[2]: rdata = int_q[15:8];
      sel[3]: rdata = cnt_q[7:0];
      sel[4]: rdata = shd_q;
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    irqen_d = irqen_q;
    int_d   = int_q;
    if (wr && sel[0]) begin
      en_d    = bus.BUS_DATA_IN[0];
      irqen_d = bus.BUS_DATA_IN[1];
    end
    if (wr && sel[1]) int_d[7:0]  = bus.BUS_DATA_IN;
    if (wr && sel[2]) int_d[15:8] = bus.BUS_DATA_IN;

    pre_d = pre_q;
    cnt_d = cnt_q;
    if (restart) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = match ? 16'd0 : cnt_q + 16'd1;
    end else if (en_q) begin
      pre_d = pre_q + PW'(1);
    end

    pend_d = pend_q;
    if (match && irqen_q)            pend_d = 1'b1;
    else if (bus.BUS_INTERRUPT_ACK)  pend_d = 1'b0;

    shd_d  = (rd && sel[3]) ? cnt_q[15:8] : shd_q;
    oen_d  = rd;
    dout_d = rd ? rdata : 8'h00;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_q    <= 1'b1;
      irqen_q <= 1'b1;
      pend_q  <= 1'b0;
      int_q   <= DEFAULT_INTERVAL;
      cnt_q   <= '0;
      pre_q   <= '0;
      shd_q   <= '0;
      dout_q  <= '0;
      oen_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      irqen_q <= irqen_d;
      pend_q  <= pend_d;
      int_q   <= int_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      shd_q   <= shd_d;
      dout_q  <= dout_d;
      oen_q   <= oen_d;
    end
  end

  assign bus.BUS_DATA_OUT        = dout_q;
  assign bus.BUS_DATA_OUT_EN     = oen_q;
  assign bus.BUS_INTERRUPT_RAISE = pend_q;
endmodule

// File: doc/bus_timer_peripheral.md
Name: bus_timer_peripheral

Overview:
Memory-mapped millisecond timer that sits on the processor's 8-bit peripheral bus as a responder. It decodes its own register window and accepts writes. It returns registered read data to the processor and raises a bus interrupt when a programmed interval elapses. It also provides a tear-free 16-bit count snapshot for the processor.

Parameters:
BASE_ADDR, 8'hF0, first address of the 5-register window (BASE..BASE+4)
CLK_FREQ_HZ, 100000000, CLK frequency
TICK_HZ, 1000, timer tick rate; prescaler terminal = CLK_FREQ_HZ/TICK_HZ - 1
DEFAULT_INTERVAL, 16'd100, interval reset value in ticks

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-low reset (0 = reset)
BUS_ADDR  input  8  bus address from processor
BUS_DATA_IN  input  8  write data from processor
BUS_WE  input  1  1 = write cycle, 0 = read cycle
BUS_DATA_OUT  output  8  read data; 8'h00 whenever BUS_DATA_OUT_EN = 0
BUS_DATA_OUT_EN  output  1  read-data valid / bus drive enable
BUS_INTERRUPT_RAISE  output  1  level interrupt request to processor
BUS_INTERRUPT_ACK  input  1  one-cycle interrupt acknowledge from processor

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 CTRL RW:
    - bit0 ENABLE
    - bit1 IRQ_EN
    - bit2 CLEAR (write-1 pulse, reads 0)
    - bit7 IRQ_PENDING (read-only)
    - other bits read 0
  - +1 INTERVAL_LO RW.
  - +2 INTERVAL_HI RW.
  - +3 COUNT_LO RO. A read returns count[7:0] and latches count[15:8] into a shadow register in the same edge.
  - +4 COUNT_HI RO. Returns the shadow register.
  - Writes to +3/+4 are ignored. Addresses outside the window are ignored entirely; no output changes.
- Reset (RESET = 0, asynchronous, immediate):
  - BUS_DATA_OUT = 0, BUS_DATA_OUT_EN = 0, BUS_INTERRUPT_RAISE = 0.
  - CTRL = 8'h03; interval = DEFAULT_INTERVAL.
  - count = 0, prescaler = 0, shadow = 0, pending = 0.
- Writes: the register updates on the edge where BUS_WE = 1 and the address is in the window. No response on BUS_DATA_OUT.
- Reads: sampled on the edge where BUS_WE = 0 and the address is in the window.
  - On that edge BUS_DATA_OUT_EN goes to 1 for exactly one cycle. BUS_DATA_OUT carries the register value as it was before that edge.
  - Latency is 1 cycle. Back-to-back reads produce back-to-back valid cycles.
- Prescaler: counts only while ENABLE = 1. At terminal it wraps to 0 and generates a one-cycle tick. With ENABLE = 0, prescaler and count hold their values.
- Count, on each tick:
  - if count == interval - 1: count goes to 0 and a match event occurs.
  - otherwise count increments.
  - Interval 0 means 65536: count wraps at 16'hFFFF and the match event occurs on that wrap.
- Match event: sets IRQ pending only if IRQ_EN = 1. BUS_INTERRUPT_RAISE = pending (registered level).
- ACK: BUS_INTERRUPT_ACK = 1 clears pending on that edge. If ACK and a match event land on the same edge, pending remains 1 (event wins).
- Restart conditions: a write to INTERVAL_LO or INTERVAL_HI, or CLEAR = 1, zeroes count and prescaler on that edge. Restart wins over a simultaneous tick. Pending is not affected by restart.
- Clearing IRQ_EN does not clear an existing pending request.
- Async reset asserted mid-count or mid-read drops all outputs immediately without a clock edge. Operation resumes from reset values on the first edge after RESET returns high.

Test Plan:
(Parameters for all scenarios: CLK_FREQ_HZ = 10, TICK_HZ = 1, so one tick every 10 cycles.)
1. Reset and read-back: release RESET, then read +0, +1, +2. Required: DATA_OUT 8'h03, 8'h64, 8'h00, each with DATA_OUT_EN high for exactly 1 cycle, 1 cycle after its address. RAISE stays 0. A read at 8'hE0 gives no DATA_OUT_EN.
2. Interval timing: write +1 = 8'h03, +2 = 8'h00. Required: RAISE rises on the 30th rising edge after the +2 write edge. It stays high until ACK, falls on the ACK edge, and rises again 30 edges after the previous rise.
3. ACK collision: hold ACK high on the exact edge of the next match event. Required: RAISE stays 1. A later lone ACK clears it.
4. Tear-free snapshot: with interval 0, run the count to 16'h00FF. Read +3, let one tick pass (count 16'h0100), then read +4. Required: 8'hFF then 8'h00. A following +3/+4 pair returns 8'h00 / 8'h01.
5. Enable, clear and IRQ_EN: write CTRL = 8'h00 and wait 50 cycles. Required: count unchanged, no RAISE. Write CTRL = 8'h07. Required: count reads 0, CTRL reads back 8'h03. With IRQ_EN = 0, a match event leaves RAISE at 0.
6. Async reset mid-operation: drive RESET low between edges while a read is in flight and pending = 1. Required: DATA_OUT_EN, DATA_OUT and RAISE go to 0 before the next edge. After release, +1 reads 8'h64.
